// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_if
// Description : Level-held read/write + wait handshake used by each bus
//               master of bus_arbiter.
//               addr     - access address
//               wdata    - write data
//               read     - read request, held until wait_req seen low
//               write    - write request (read+write together = write)
//               rdata    - read data returned to the master
//               wait_req - master stall (the mN_wait signal; "wait" is a
//                          reserved word, hence the suffix)
//               modport master : the requesting side
//               modport slave  : the arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] rdata;
    logic              wait_req;

    modport master (
        output addr, wdata, read, write,
        input  rdata, wait_req
    );

    modport slave (
        input  addr, wdata, read, write,
        output rdata, wait_req
    );
endinterface
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Shares one byte-wide memory port between two bus masters
//               (m0 = CPU core, m1 = secondary master). Round-robin
//               arbitration on ties, one memory access in flight at a time,
//               forced completion after TIMEOUT access cycles without ack.
// Ports       : clk         - clock
//               rst_n       - asynchronous active-low reset
//               m0, m1      - master handshake interfaces (slave modport)
//               mem_req     - memory request, held until ack or timeout
//               mem_we      - 1 = write, 0 = read
//               mem_addr    - memory address
//               mem_wdata   - memory write data
//               mem_rdata   - memory read data, valid with mem_ack
//               mem_ack     - one-cycle completion from memory
//               grant       - index of current / last granted master
//               timeout_err - one-cycle pulse during a forced completion
// Parameters  : ADDR_W, DATA_W, TIMEOUT (1..255, 8-bit cycle counter)
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_arbiter_if.slave      m0,
    bus_arbiter_if.slave      m1,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              grant,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Last counter value of an unanswered access; reaching it without ack
    // forces completion, so an access occupies at most TIMEOUT cycles.
    localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state_q,       state_d;
    logic              grant_q,       grant_d;
    logic              last_grant_q,  last_grant_d;
    logic              mem_req_q,     mem_req_d;
    logic              mem_we_q,      mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q,   mem_wdata_d;
    logic [DATA_W-1:0] rdata_hold_q,  rdata_hold_d;
    logic              timeout_err_q, timeout_err_d;
    logic [7:0]        cnt_q,         cnt_d;

    logic req0;
    logic req1;
    logic arb_sel;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    // Round-robin: on a tie the master that did not win last time goes
    // first; otherwise the lone requester wins (req1 selects index 1).
    assign arb_sel = (req0 & req1) ? ~last_grant_q : req1;

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_hold_d  = rdata_hold_q;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req0 | req1) begin
                    state_d      = ST_ACCESS;
                    grant_d      = arb_sel;
                    last_grant_d = arb_sel;
                    mem_req_d    = 1'b1;
                    // write bit alone decides direction: read+write is a write
                    mem_we_d     = arb_sel ? m1.write : m0.write;
                    mem_addr_d   = arb_sel ? m1.addr  : m0.addr;
                    mem_wdata_d  = arb_sel ? m1.wdata : m0.wdata;
                    cnt_d        = 8'd0;
                end
            end

            ST_ACCESS: begin
                // An ack on the timeout cycle takes priority: no error.
                if (mem_ack) begin
                    if (!mem_we_q) begin
                        rdata_hold_d = mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (cnt_q == C_TMO_LAST) begin
                    mem_req_d     = 1'b0;
                    rdata_hold_d  = '1;
                    timeout_err_d = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_DONE: begin
                timeout_err_d = 1'b0;
                state_d       = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;   // master 0 wins the first tie
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rdata_hold_q  <= '0;
            timeout_err_q <= 1'b0;
            cnt_q         <= 8'd0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_hold_q  <= rdata_hold_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

    // Wait is combinational on the request so a master stalls from the very
    // cycle it asks; it drops only in the DONE cycle of its own access.
    assign m0.wait_req = req0 & ~((state_q == ST_DONE) & (grant_q == 1'b0));
    assign m1.wait_req = req1 & ~((state_q == ST_DONE) & (grant_q == 1'b1));
    assign m0.rdata    = rdata_hold_q;
    assign m1.rdata    = rdata_hold_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Self-checking bench for bus_arbiter (TIMEOUT = 4).
//               Directed rounds from a table, hand sequences for continuous
//               contention and asynchronous reset mid-access, then random
//               rounds whose expectations come from a transaction-level
//               model (service order, access lengths, returned data).
//               A "round" starts in IDLE at cycle 0 with one or both masters
//               raising a request; each master drops it after seeing wait low.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

    localparam int TMO    = 4;
    localparam int RND_CY = 14;
    localparam int N_RAND = 40;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        grant;
    logic        timeout_err;

    bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) m0_bus ();
    bus_arbiter_if #(.ADDR_W(16), .DATA_W(8)) m1_bus ();

    bus_arbiter #(.ADDR_W(16), .DATA_W(8), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0          (m0_bus),
        .m1          (m1_bus),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // op encoding: bit0 = read, bit1 = write
    typedef struct {
        logic [1:0]  op0;
        logic [15:0] a0;
        logic [7:0]  wd0;
        logic [1:0]  op1;
        logic [15:0] a1;
        logic [7:0]  wd1;
        int          lat_a;   // memory wait cycles before ack, 1st access (>=TMO: none)
        logic [7:0]  rd_a;
        int          lat_b;   // same for the 2nd access of the round
        logic [7:0]  rd_b;
        int          first;   // master served first
        int          done_a;  // DONE cycle of 1st access
        logic [7:0]  er_a;    // rdata seen in that DONE cycle
        logic        to_a;
        int          done_b;  // -1 when only one access
        logic [7:0]  er_b;
        logic        to_b;
    } vec_t;

    int         total = 0;
    int         bad   = 0;

    // memory responder state
    int         mem_lat [4];
    logic [7:0] mem_rd  [4];
    int         acc_idx;
    int         acc_cyc;
    logic       mem_prev;

    // reference model state
    int         m_last;
    logic [7:0] m_rhold;

    vec_t       tbl [8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Acks the n-th access of a round after mem_lat[n] wait cycles.
    task automatic mem_step();
        mem_ack   = 1'b0;
        mem_rdata = 8'($urandom);
        if (mem_req) begin
            if (!mem_prev) begin
                acc_idx++;
                acc_cyc = 0;
            end else begin
                acc_cyc++;
            end
            if (acc_idx >= 0 && acc_idx < 4 && acc_cyc == mem_lat[acc_idx]) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_rd[acc_idx];
            end
        end
        mem_prev = mem_req;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        mem_step();
    endtask

    function automatic vec_t mk(input logic [1:0] op0, input logic [15:0] a0, input logic [7:0] wd0,
                                input logic [1:0] op1, input logic [15:0] a1, input logic [7:0] wd1,
                                input int lat_a, input logic [7:0] rd_a,
                                input int lat_b, input logic [7:0] rd_b,
                                input int first, input int done_a, input logic [7:0] er_a, input logic to_a,
                                input int done_b, input logic [7:0] er_b, input logic to_b);
        vec_t v;
        v.op0 = op0; v.a0 = a0; v.wd0 = wd0;
        v.op1 = op1; v.a1 = a1; v.wd1 = wd1;
        v.lat_a = lat_a; v.rd_a = rd_a; v.lat_b = lat_b; v.rd_b = rd_b;
        v.first = first; v.done_a = done_a; v.er_a = er_a; v.to_a = to_a;
        v.done_b = done_b; v.er_b = er_b; v.to_b = to_b;
        return v;
    endfunction

    // Transaction-level reference: who goes first, how long each access
    // lasts (ack after lat waits, capped at TMO cycles) and what data the
    // master sees when released.
    function automatic vec_t model(input vec_t v);
        vec_t       r;
        int         m   [2];
        int         lat [2];
        logic [7:0] rd  [2];
        int         n;
        int         t;
        int         len;
        int         dn  [2];
        logic [7:0] er  [2];
        logic       to  [2];
        logic [1:0] op;
        r   = v;
        lat = '{v.lat_a, v.lat_b};
        rd  = '{v.rd_a, v.rd_b};
        dn  = '{-1, -1};
        er  = '{8'h00, 8'h00};
        to  = '{1'b0, 1'b0};
        if (v.op0 != 2'd0 && v.op1 != 2'd0) begin
            m[0] = 1 - m_last;
            n    = 2;
        end else begin
            m[0] = (v.op0 != 2'd0) ? 0 : 1;
            n    = 1;
        end
        m[1] = 1 - m[0];
        t = 1;
        for (int i = 0; i < n; i++) begin
            op    = (m[i] == 0) ? v.op0 : v.op1;
            len   = (lat[i] < TMO) ? lat[i] + 1 : TMO;
            to[i] = (lat[i] >= TMO);
            dn[i] = t + len;
            if (to[i])
                m_rhold = 8'hFF;
            else if (!op[1])
                m_rhold = rd[i];
            er[i]  = m_rhold;
            m_last = m[i];
            t      = dn[i] + 2;
        end
        r.first  = m[0];
        r.done_a = dn[0]; r.er_a = er[0]; r.to_a = to[0];
        r.done_b = dn[1]; r.er_b = er[1]; r.to_b = to[1];
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int         am;
        int         done_m [2];
        logic [7:0] er_m   [2];
        logic       act    [2];
        logic       mw     [2];
        logic       exp_req;
        logic       exp_to;
        int         cm;
        logic [1:0] op;
        am        = v.first;
        done_m    = '{-1, -1};
        er_m      = '{8'h00, 8'h00};
        done_m[am]   = v.done_a;
        er_m[am]     = v.er_a;
        if (v.done_b >= 0) begin
            done_m[1-am] = v.done_b;
            er_m[1-am]   = v.er_b;
        end
        mem_lat = '{v.lat_a, v.lat_b, 99, 99};
        mem_rd  = '{v.rd_a, v.rd_b, 8'h00, 8'h00};
        acc_idx = -1;
        act     = '{v.op0 != 2'd0, v.op1 != 2'd0};
        m0_bus.addr  = v.a0;  m0_bus.wdata = v.wd0;
        m1_bus.addr  = v.a1;  m1_bus.wdata = v.wd1;
        for (int c = 0; c < RND_CY; c++) begin
            m0_bus.read  = act[0] & v.op0[0];
            m0_bus.write = act[0] & v.op0[1];
            m1_bus.read  = act[1] & v.op1[0];
            m1_bus.write = act[1] & v.op1[1];
            @(negedge clk);
            mw = '{m0_bus.wait_req, m1_bus.wait_req};
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("%s c%0d wait%0d", tag, c, m), 32'(mw[m]), 32'(act[m] && c != done_m[m]));
                if (c == done_m[m]) begin
                    chk($sformatf("%s c%0d grant", tag, c), 32'(grant), 32'(m));
                    chk($sformatf("%s c%0d rdata%0d", tag, c, m),
                        32'((m == 0) ? m0_bus.rdata : m1_bus.rdata), 32'(er_m[m]));
                end
            end
            exp_to  = (c == v.done_a && v.to_a) || (v.done_b >= 0 && c == v.done_b && v.to_b);
            exp_req = (c >= 1 && c < v.done_a) ||
                      (v.done_b >= 0 && c >= v.done_a + 2 && c < v.done_b);
            chk($sformatf("%s c%0d timeout_err", tag, c), 32'(timeout_err), 32'(exp_to));
            chk($sformatf("%s c%0d mem_req", tag, c), 32'(mem_req), 32'(exp_req));
            if (exp_req) begin
                cm = (c < v.done_a) ? am : 1 - am;
                op = (cm == 0) ? v.op0 : v.op1;
                chk($sformatf("%s c%0d mem_addr", tag, c), 32'(mem_addr), 32'((cm == 0) ? v.a0 : v.a1));
                chk($sformatf("%s c%0d mem_wdata", tag, c), 32'(mem_wdata), 32'((cm == 0) ? v.wd0 : v.wd1));
                chk($sformatf("%s c%0d mem_we", tag, c), 32'(mem_we), 32'(op[1]));
            end
            for (int m = 0; m < 2; m++)
                if (act[m] && !mw[m]) act[m] = 1'b0;
            next_cycle();
        end
        m0_bus.read = 1'b0; m0_bus.write = 1'b0;
        m1_bus.read = 1'b0; m1_bus.write = 1'b0;
        chk($sformatf("%s m0 pending at end", tag), 32'(act[0]), 32'd0);
        chk($sformatf("%s m1 pending at end", tag), 32'(act[1]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t       v;
        int         ndone;
        int         gexp [4];
        logic [7:0] cdat [4];

        // directed rounds; state entering: last_grant=1, rdata_hold=0x40
        //             op0   a0        wd0    op1   a1        wd1    la rda    lb rdb    f  da era    ta db  erb    tb
        tbl[0] = mk(2'd1, 16'h1234, 8'h00, 2'd0, 16'h0000, 8'h00, 0, 8'h5A, 0, 8'h00, 0, 2, 8'h5A, 0, -1, 8'h00, 0);
        tbl[1] = mk(2'd0, 16'h0000, 8'h00, 2'd2, 16'h8000, 8'hC3, 2, 8'hEE, 0, 8'h00, 1, 4, 8'h5A, 0, -1, 8'h00, 0);
        tbl[2] = mk(2'd1, 16'h0ABC, 8'h00, 2'd0, 16'h0000, 8'h00, 9, 8'h00, 0, 8'h00, 0, 5, 8'hFF, 1, -1, 8'h00, 0);
        tbl[3] = mk(2'd1, 16'h1000, 8'h01, 2'd1, 16'h2000, 8'h02, 1, 8'h11, 1, 8'h22, 1, 3, 8'h11, 0,  7, 8'h22, 0);
        tbl[4] = mk(2'd1, 16'h1001, 8'h03, 2'd1, 16'h2001, 8'h04, 1, 8'h33, 1, 8'h44, 1, 3, 8'h33, 0,  7, 8'h44, 0);
        tbl[5] = mk(2'd3, 16'h00FF, 8'h99, 2'd0, 16'h0000, 8'h00, 0, 8'hEE, 0, 8'h00, 0, 2, 8'h44, 0, -1, 8'h00, 0);
        tbl[6] = mk(2'd0, 16'h0000, 8'h00, 2'd1, 16'h7777, 8'h00, 3, 8'h77, 0, 8'h00, 1, 5, 8'h77, 0, -1, 8'h00, 0);
        tbl[7] = mk(2'd2, 16'h0001, 8'hA5, 2'd1, 16'hFFFF, 8'h00, 0, 8'hEE, 9, 8'h00, 0, 2, 8'h77, 0,  8, 8'hFF, 1);

        rst_n = 1'b0;
        m0_bus.read = 1'b0; m0_bus.write = 1'b0; m0_bus.addr = 16'h0; m0_bus.wdata = 8'h0;
        m1_bus.read = 1'b0; m1_bus.write = 1'b0; m1_bus.addr = 16'h0; m1_bus.wdata = 8'h0;
        mem_ack = 1'b0; mem_rdata = 8'h00; mem_prev = 1'b0; acc_idx = -1; acc_cyc = 0;
        mem_lat = '{99, 99, 99, 99};
        mem_rd  = '{8'h00, 8'h00, 8'h00, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        chk("rst mem_req",     32'(mem_req),      32'd0);
        chk("rst mem_we",      32'(mem_we),       32'd0);
        chk("rst mem_addr",    32'(mem_addr),     32'd0);
        chk("rst mem_wdata",   32'(mem_wdata),    32'd0);
        chk("rst grant",       32'(grant),        32'd0);
        chk("rst timeout_err", 32'(timeout_err),  32'd0);
        chk("rst m0_rdata",    32'(m0_bus.rdata), 32'd0);
        chk("rst m1_wait",     32'(m1_bus.wait_req), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        next_cycle();

        // continuous contention, 1 memory wait cycle: 0,1,0,1 every 4 cycles
        gexp  = '{0, 1, 0, 1};
        cdat  = '{8'h10, 8'h20, 8'h30, 8'h40};
        mem_lat = '{1, 1, 1, 1};
        mem_rd  = cdat;
        acc_idx = -1;
        ndone   = 0;
        m0_bus.addr = 16'h0100; m0_bus.read = 1'b1;
        m1_bus.addr = 16'h0200; m1_bus.read = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (!m0_bus.wait_req || !m1_bus.wait_req) begin
                if (ndone < 4) begin
                    chk($sformatf("cont #%0d grant", ndone), 32'(grant), 32'(gexp[ndone]));
                    chk($sformatf("cont #%0d cycle", ndone), 32'(c), 32'(3 + 4 * ndone));
                    chk($sformatf("cont #%0d waits", ndone), 32'({m1_bus.wait_req, m0_bus.wait_req}),
                        32'((gexp[ndone] == 0) ? 2'b10 : 2'b01));
                    chk($sformatf("cont #%0d rdata", ndone), 32'(m0_bus.rdata), 32'(cdat[ndone]));
                end
                ndone++;
            end
            next_cycle();
        end
        m0_bus.read = 1'b0; m1_bus.read = 1'b0;
        chk("cont completions", 32'(ndone), 32'd4);
        repeat (2) next_cycle();

        for (int i = 0; i < 8; i++)
            run_vec(tbl[i], $sformatf("tbl%0d", i));

        // asynchronous reset in the middle of an unanswered access
        mem_lat = '{99, 99, 99, 99};
        acc_idx = -1;
        m0_bus.addr = 16'h4444; m0_bus.read = 1'b1;
        repeat (2) next_cycle();
        @(negedge clk);
        chk("arst mem_req before", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst mem_req",     32'(mem_req),      32'd0);
        chk("arst mem_addr",    32'(mem_addr),     32'd0);
        chk("arst grant",       32'(grant),        32'd0);
        chk("arst timeout_err", 32'(timeout_err),  32'd0);
        chk("arst m0_rdata",    32'(m0_bus.rdata), 32'd0);
        chk("arst m0_wait",     32'(m0_bus.wait_req), 32'd1);
        m0_bus.read = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        next_cycle();
        m_last  = 1;
        m_rhold = 8'h00;

        // after reset: a tie goes to m0, a lone m1 request goes to m1
        v = mk(2'd1, 16'h0011, 8'h00, 2'd1, 16'h0022, 8'h00, 0, 8'h61, 0, 8'h62, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        run_vec(model(v), "post-rst tie");
        v = mk(2'd0, 16'h0011, 8'h00, 2'd1, 16'h0033, 8'h00, 1, 8'h63, 0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0);
        run_vec(model(v), "post-rst m1");

        for (int i = 0; i < N_RAND; i++) begin
            v.op0   = 2'($urandom_range(0, 3));
            v.op1   = 2'($urandom_range(0, 3));
            if (v.op0 == 2'd0 && v.op1 == 2'd0) v.op0 = 2'd1;
            v.a0    = 16'($urandom);  v.wd0 = 8'($urandom);
            v.a1    = 16'($urandom);  v.wd1 = 8'($urandom);
            v.lat_a = $urandom_range(0, 5); v.rd_a = 8'($urandom);
            v.lat_b = $urandom_range(0, 5); v.rd_b = 8'($urandom);
            run_vec(model(v), $sformatf("rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
